meter_scheduler: RTL and testbench

Sequencing controller for the averaging voltage/current meter. It issues meter start pulses, either periodically from a programmable timer or on a host one-shot request, and tracks the meter's busy handshake to detect completion. On completion it captures the 12-bit V/I results and runs consecutive-sample over-limit checks. Sticky fault, timeout and overrun flags go to the supervisory logic.

---
 rtl/meter_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_meter_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meter_scheduler.sv
// -----------------------------------------------------------------------------
// meter_scheduler
//
// Sequencing controller for the averaging voltage/current meter. Issues a
// one-cycle meter_start either from a programmable period timer or from a host
// one-shot request. It then follows the meter busy handshake (busy falls for
// the final averaged sample and rises again when results update). On completion
// it captures the V/I results and runs consecutive-sample over-limit checks.
// Sticky fault, timeout and overrun flags go to the supervisory logic.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   enable, period           periodic mode enable and start-to-start interval
//   req, ack                 one-shot request in, completion pulse out
//   meter_start, meter_busy  meter handshake
//   meter_data_v/_i          12-bit meter results
//   v_limit, i_limit         over-limit thresholds (strict greater-than)
//   sample_v/_i              last captured results
//   sample_valid             one-cycle pulse on a new capture
//   sample_count             completed conversions (wrapping)
//   ov_fault, oc_fault       sticky over-voltage / over-current flags
//   timeout_err, overrun     sticky handshake-timeout / missed-tick flags
//   fault_clear              clears sticky flags and consecutive counters
// -----------------------------------------------------------------------------
module meter_scheduler #(
  parameter int PERIOD_W       = 24,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FAULT_COUNT    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                req,
  output logic                ack,
  output logic                meter_start,
  input  logic                meter_busy,
  input  logic [11:0]         meter_data_v,
  input  logic [11:0]         meter_data_i,
  input  logic [11:0]         v_limit,
  input  logic [11:0]         i_limit,
  output logic [11:0]         sample_v,
  output logic [11:0]         sample_i,
  output logic                sample_valid,
  output logic [15:0]         sample_count,
  output logic                ov_fault,
  output logic                oc_fault,
  output logic                timeout_err,
  output logic                overrun,
  input  logic                fault_clear
);

  localparam int          TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]  FC     = 4'(FAULT_COUNT);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_LOW  = 3'd2;
  localparam logic [2:0] WAIT_HIGH = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;

  logic [2:0]          state;
  logic [PERIOD_W-1:0] timer;
  logic                pend_per;
  logic                pend_req;
  logic                serve_req;
  logic [TO_W-1:0]     to_cnt;
  logic [3:0]          ov_cnt;
  logic [3:0]          oc_cnt;

  // Period timer: a tick whenever the enabled timer sits at zero, so the first
  // tick lands in the first enabled cycle. A period of 0 behaves as 1.
  logic                tick;
  logic [PERIOD_W-1:0] reload;
  assign tick   = enable && (timer == '0);
  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);

  // Handshake progress and timeout. Progress in the same cycle as the last
  // allowed wait cycle takes priority over the timeout.
  logic            in_wait;
  logic            capture;
  logic            advance;
  logic [TO_W-1:0] to_inc;
  logic            to_hit;
  assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign capture = (state == WAIT_HIGH) && meter_busy;
  assign advance = ((state == WAIT_LOW) && !meter_busy) || capture;
  assign to_inc  = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
  assign to_hit  = in_wait && !advance && (to_inc == TO_MAX);

  // Consecutive over-limit counters. A fault_clear coinciding with a capture
  // restarts the count from zero before the new sample is applied.
  logic       v_over;
  logic       i_over;
  logic [3:0] ov_base;
  logic [3:0] oc_base;
  logic [3:0] ov_next;
  logic [3:0] oc_next;
  assign v_over  = meter_data_v > v_limit;
  assign i_over  = meter_data_i > i_limit;
  assign ov_base = fault_clear ? 4'd0 : ov_cnt;
  assign oc_base = fault_clear ? 4'd0 : oc_cnt;
  assign ov_next = !v_over ? 4'd0 : (ov_base == 4'hF) ? ov_base : ov_base + 4'd1;
  assign oc_next = !i_over ? 4'd0 : (oc_base == 4'hF) ? oc_base : oc_base + 4'd1;

  // Timer and pending flags. In IDLE the pending flags are consumed, so only a
  // new event arriving that cycle survives.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      pend_per <= 1'b0;
      pend_req <= 1'b0;
    end else begin
      if (!enable)  timer <= '0;
      else if (tick) timer <= reload;
      else          timer <= timer - PERIOD_W'(1);

      if (state == IDLE) begin
        pend_per <= tick;
        pend_req <= req;
      end else begin
        pend_per <= pend_per | tick;
        pend_req <= pend_req | req;
      end
    end
  end

  // Conversion sequencer. Everything reported in CHECK is registered on the
  // WAIT_HIGH->CHECK edge so it appears together with sample_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      serve_req    <= 1'b0;
      to_cnt       <= '0;
      meter_start  <= 1'b0;
      sample_valid <= 1'b0;
      ack          <= 1'b0;
      sample_v     <= '0;
      sample_i     <= '0;
      sample_count <= '0;
    end else begin
      meter_start  <= 1'b0;
      sample_valid <= 1'b0;
      ack          <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_per || pend_req) begin
            state       <= START;
            serve_req   <= pend_req;
            meter_start <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          to_cnt <= to_inc;
          if (capture) begin
            state        <= CHECK;
            sample_v     <= meter_data_v;
            sample_i     <= meter_data_i;
            sample_valid <= 1'b1;
            sample_count <= sample_count + 16'd1;
            ack          <= serve_req;
          end else if (advance) begin
            state <= WAIT_HIGH;
          end else if (to_hit) begin
            state <= IDLE;
            ack   <= serve_req;
          end
        end
        CHECK: begin
          state     <= IDLE;
          serve_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags and consecutive counters; a set condition beats fault_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_cnt      <= '0;
      oc_cnt      <= '0;
      ov_fault    <= 1'b0;
      oc_fault    <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (capture) begin
        ov_cnt <= ov_next;
        oc_cnt <= oc_next;
      end else if (fault_clear) begin
        ov_cnt <= '0;
        oc_cnt <= '0;
      end

      if (capture && (ov_next >= FC))       ov_fault <= 1'b1;
      else if (fault_clear)                 ov_fault <= 1'b0;

      if (capture && (oc_next >= FC))       oc_fault <= 1'b1;
      else if (fault_clear)                 oc_fault <= 1'b0;

      if (to_hit)                           timeout_err <= 1'b1;
      else if (fault_clear)                 timeout_err <= 1'b0;

      // Tick merged into an already pending one while a conversion runs.
      if (tick && pend_per && (state != IDLE)) overrun <= 1'b1;
      else if (fault_clear)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_meter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_meter_scheduler
//
// Self-checking bench for meter_scheduler. Stimulus pushes the expected
// response of each conversion into a scoreboard queue; a separate monitor pops
// and compares whenever the DUT reports (sample_valid or ack). A behavioral
// meter model answers meter_start with a programmable busy high/low profile.
// -----------------------------------------------------------------------------
module tb_meter_scheduler;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] period;
  logic          req;
  logic          ack;
  logic          meter_start;
  logic          meter_busy;
  logic [11:0]   meter_data_v;
  logic [11:0]   meter_data_i;
  logic [11:0]   v_limit;
  logic [11:0]   i_limit;
  logic [11:0]   sample_v;
  logic [11:0]   sample_i;
  logic          sample_valid;
  logic [15:0]   sample_count;
  logic          ov_fault;
  logic          oc_fault;
  logic          timeout_err;
  logic          overrun;
  logic          fault_clear;

  meter_scheduler #(
    .PERIOD_W      (PW),
    .TIMEOUT_CYCLES(1000),
    .FAULT_COUNT   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
    .req         (req),
    .ack         (ack),
    .meter_start (meter_start),
    .meter_busy  (meter_busy),
    .meter_data_v(meter_data_v),
    .meter_data_i(meter_data_i),
    .v_limit     (v_limit),
    .i_limit     (i_limit),
    .sample_v    (sample_v),
    .sample_i    (sample_i),
    .sample_valid(sample_valid),
    .sample_count(sample_count),
    .ov_fault    (ov_fault),
    .oc_fault    (oc_fault),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sv;
    bit          ack;
    bit          tmo;
    logic [11:0] v;
    logic [11:0] i;
    logic [15:0] cnt;
    bit          ov;
    bit          oc;
    bit          to;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Meter model controls and observations.
  int          m_hi = 20;
  int          m_lo = 10;
  logic [11:0] m_v = '0;
  logic [11:0] m_i = '0;
  bit          m_stuck = 1'b0;
  int          rise_cyc = 0;

  int n_starts = 0;
  int last_start_cyc = 0;
  int start_q[$];
  int ack_total = 0;
  int req_cyc = 0;

  // Reference model of expected outputs.
  logic [15:0] exp_cnt = '0;
  logic [11:0] exp_v = '0;
  logic [11:0] exp_i = '0;
  int          ovc = 0;
  int          occ = 0;
  bit          exp_ov = 1'b0;
  bit          exp_oc = 1'b0;
  bit          exp_to = 1'b0;

  logic [11:0] vseq [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioral meter: busy stays high m_hi cycles after start, drops for m_lo
  // cycles, then rises together with the new results.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    meter_busy = 1'b1;
    meter_data_v = '0;
    meter_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        meter_busy = 1'b1;
        meter_data_v = '0;
        meter_data_i = '0;
      end else begin
        case (phase)
          0: if (meter_start && !m_stuck) begin phase = 1; cnt = m_hi; end
          1: begin
            cnt--;
            if (cnt == 0) begin meter_busy = 1'b0; phase = 2; cnt = m_lo; end
          end
          2: begin
            cnt--;
            if (cnt == 0) begin
              meter_busy = 1'b1;
              meter_data_v = m_v;
              meter_data_i = m_i;
              rise_cyc = cyc;
              phase = 0;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // Monitor: counts starts and pops the scoreboard on every DUT report.
  initial forever begin
    @(negedge clk);
    if (!rst && meter_start) begin
      n_starts++;
      last_start_cyc = cyc;
      start_q.push_back(cyc);
    end
    if (!rst && ack) ack_total++;
    if (!rst && (sample_valid || ack)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("sample_valid", sample_valid, e_mon.sv);
        check("ack", ack, e_mon.ack);
        check("sample_v", sample_v, e_mon.v);
        check("sample_i", sample_i, e_mon.i);
        check("sample_count", sample_count, e_mon.cnt);
        check("ov_fault", ov_fault, e_mon.ov);
        check("oc_fault", oc_fault, e_mon.oc);
        check("timeout_err", timeout_err, e_mon.to);
        if (e_mon.sv)  check("capture_latency", cyc - rise_cyc, 1);
        if (e_mon.tmo) check("timeout_latency", cyc - last_start_cyc, 1001);
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end

  task automatic exp_conv(input logic [11:0] v, input logic [11:0] i, input bit serve);
    exp_t e;
    m_v = v;
    m_i = i;
    exp_cnt = exp_cnt + 16'd1;
    ovc = (v > v_limit) ? ((ovc == 15) ? 15 : ovc + 1) : 0;
    occ = (i > i_limit) ? ((occ == 15) ? 15 : occ + 1) : 0;
    if (ovc >= 3) exp_ov = 1'b1;
    if (occ >= 3) exp_oc = 1'b1;
    exp_v = v;
    exp_i = i;
    e.sv = 1'b1; e.ack = serve; e.tmo = 1'b0;
    e.v = v; e.i = i; e.cnt = exp_cnt;
    e.ov = exp_ov; e.oc = exp_oc; e.to = exp_to;
    sb.push_back(e);
  endtask

  task automatic exp_timeout(input bit serve);
    exp_t e;
    exp_to = 1'b1;
    e.sv = 1'b0; e.ack = serve; e.tmo = 1'b1;
    e.v = exp_v; e.i = exp_i; e.cnt = exp_cnt;
    e.ov = exp_ov; e.oc = exp_oc; e.to = exp_to;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    exp_cnt = '0; exp_v = '0; exp_i = '0;
    ovc = 0; occ = 0;
    exp_ov = 1'b0; exp_oc = 1'b0; exp_to = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (n_starts < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, n_starts >= target, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_meter_start"}, meter_start, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_sample_v"}, sample_v, 0);
    check({tag, "_sample_i"}, sample_i, 0);
    check({tag, "_sample_count"}, sample_count, 0);
    check({tag, "_ov_fault"}, ov_fault, 0);
    check({tag, "_oc_fault"}, oc_fault, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    req = 1'b0;
    fault_clear = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero(tag);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int base;
    int k;
    rst = 1'b1;
    enable = 1'b0;
    period = '0;
    req = 1'b0;
    fault_clear = 1'b0;
    v_limit = 12'h800;
    i_limit = 12'h800;
    vseq[0] = 12'h900; vseq[1] = 12'h900; vseq[2] = 12'h800;
    vseq[3] = 12'h900; vseq[4] = 12'h900; vseq[5] = 12'h900;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: 20 high, 10 low, then V=0x123 I=0x045.
    m_hi = 20; m_lo = 10;
    base = n_starts;
    exp_conv(12'h123, 12'h045, 1'b1);
    pulse_req();
    wait_starts("req_start_seen", base + 1, 10);
    check("req_latency", last_start_cyc - req_cyc, 2);
    wait_drain("req_drain", 100);
    check("single_start", n_starts - base, 1);

    // Over-voltage debounce: fault only on the 6th sample.
    for (int s = 0; s < 6; s++) begin
      exp_conv(vseq[s], 12'h010, 1'b1);
      pulse_req();
      wait_drain("ov_drain", 100);
    end
    check("ov_before_clear", ov_fault, 1);
    @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    ovc = 0; occ = 0; exp_ov = 1'b0; exp_oc = 1'b0; exp_to = 1'b0;
    check("ov_after_clear", ov_fault, 0);

    // Timeout: busy stuck high, then a normal conversion afterwards.
    m_stuck = 1'b1;
    exp_timeout(1'b1);
    pulse_req();
    wait_drain("timeout_drain", 1200);
    check("timeout_count_held", sample_count, exp_cnt);
    check("timeout_flag", timeout_err, 1);
    m_stuck = 1'b0;
    exp_conv(12'h200, 12'h100, 1'b1);
    pulse_req();
    wait_drain("post_timeout_drain", 100);

    // Periodic spacing: period 100, 40-cycle conversions.
    do_reset("reset2");
    m_hi = 20; m_lo = 20;
    start_q.delete();
    base = n_starts;
    for (int s = 0; s < 5; s++) exp_conv(12'h300, 12'h100, 1'b0);
    period = 24'd100;
    @(negedge clk);
    enable = 1'b1;
    wait_starts("periodic_starts_seen", base + 5, 600);
    wait_drain("periodic_drain", 100);
    enable = 1'b0;
    check("periodic_start_count", start_q.size(), 5);
    k = start_q.size();
    for (int s = 0; s < 4 && s + 1 < k; s++)
      check("periodic_spacing", start_q[s+1] - start_q[s], 100);
    check("periodic_sample_count", sample_count, 5);
    check("periodic_overrun", overrun, 0);
    repeat (10) @(negedge clk);

    // Overrun and merge: period 10, 40-cycle conversions, req merged.
    period = 24'd10;
    base = n_starts;
    exp_conv(12'h300, 12'h100, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    k = 0;
    while (!overrun && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("overrun_set", overrun, 1);
    enable = 1'b0;
    exp_conv(12'h300, 12'h100, 1'b1);
    pulse_req();
    wait_drain("merge_drain", 200);
    repeat (100) @(negedge clk);
    check("merge_start_count", n_starts - base, 2);
    check("overrun_sticky", overrun, 1);

    // Reset mid-conversion while in WAIT_HIGH.
    base = ack_total;
    m_v = 12'h555; m_i = 12'h066;
    pulse_req();
    k = 0;
    while (meter_busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("busy_low_seen", meter_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("no_ack_after_rst", ack_total - base, 0);
    exp_conv(12'h0AA, 12'h0BB, 1'b1);
    pulse_req();
    wait_drain("after_rst_drain", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
